// File: rtl/pipeline_coproc0_vec.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_coproc0_vec
// Brief    : Coprocessor-0 exception unit. Handles overflow, invalid-instruction
//            and NUM_IRQ edge-latched interrupts, and vectors each source to its
//            own handler address.
//            Optional macro COP0_TIMER_EN adds count/compare timer interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_coproc0_vec #(
  parameter int          NUM_IRQ       = 4,
  parameter logic [29:0] VECTOR_BASE   = 30'h002,
  parameter logic [29:0] VECTOR_STRIDE = 30'h004
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_we,
  input  logic [31:0]        i_addr,
  input  logic [31:0]        i_data,
  input  logic [29:0]        i_pc,
  input  logic               i_overflow,
  input  logic               i_invalid_instr,
  input  logic [NUM_IRQ-1:0] i_irq,
  input  logic               i_eret,
  output logic [31:0]        o_data,
  output logic [29:0]        o_return_addr,
  output logic [29:0]        o_instr_addr,
  output logic               o_interrupt,
  output logic               o_busy
);

`ifdef COP0_TIMER_EN
  localparam int NPEND = NUM_IRQ + 1;
`else
  localparam int NPEND = NUM_IRQ;
`endif
  localparam int NSRC = NPEND + 2;

  localparam logic [31:0] ADDR_STATUS  = 32'h0000_0060;
  localparam logic [31:0] ADDR_CAUSE   = 32'h0000_0068;
  localparam logic [31:0] ADDR_EPC     = 32'h0000_0070;
`ifdef COP0_TIMER_EN
  localparam logic [31:0] ADDR_COUNT   = 32'h0000_0080;
  localparam logic [31:0] ADDR_COMPARE = 32'h0000_0088;
`endif
  localparam logic [31:0] STATUS_RST   = 32'h8000_0003;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [31:0]      status_q, status_d;
  logic [NPEND-1:0] pend_q, pend_d;
  logic [4:0]       code_q, code_d;
  logic [29:0]      epc_q, epc_d;
  logic [NUM_IRQ-1:0] irq_prev_q;

  logic [NSRC-1:0]  req;
  logic [4:0]       req_code;
  logic [29:0]      vec_addr;
  logic             take;
  logic [NUM_IRQ-1:0] irq_rise;
  logic             we_status, we_cause, we_epc;
  logic [31:0]      cause_rd;

  assign we_status = i_we && (i_addr == ADDR_STATUS);
  assign we_cause  = i_we && (i_addr == ADDR_CAUSE);
  assign we_epc    = i_we && (i_addr == ADDR_EPC);
  assign irq_rise  = i_irq & ~irq_prev_q;

`ifdef COP0_TIMER_EN
  logic [31:0] count_q, count_d, compare_q, compare_d, count_inc;
  logic        we_count, we_compare, tmr_hit;

  assign we_count   = i_we && (i_addr == ADDR_COUNT);
  assign we_compare = i_we && (i_addr == ADDR_COMPARE);
  assign count_inc  = count_q + 32'd1;
  assign count_d    = we_count ? i_data : count_inc;
  assign compare_d  = we_compare ? i_data : compare_q;
  // A software load is not an increment, so it never raises a match.
  assign tmr_hit    = !we_count && (count_inc == compare_q);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q   <= 32'd0;
      compare_q <= 32'd0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
    end
  end
`endif

  // Request vector; bit index equals the exception code, so lowest index wins.
  assign req[0] = i_overflow      & status_q[0];
  assign req[1] = i_invalid_instr & status_q[1];
  for (genvar k = 0; k < NPEND; k++) begin : g_pend_req
    assign req[2+k] = pend_q[k] & status_q[8+k];
  end

  always_comb begin
    req_code = 5'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) req_code = 5'(i);
    end
  end

  assign vec_addr = VECTOR_BASE + ({25'd0, req_code} * VECTOR_STRIDE);

  // FSM: state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (take)   state_d = ST_BUSY;
      ST_BUSY: if (i_eret) state_d = ST_IDLE;
      default:             state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    o_busy = (state_q == ST_BUSY);
    take   = status_q[31] && (state_q == ST_IDLE) && (|req);
  end

  always_comb begin
    status_d = we_status ? i_data : status_q;
    code_d   = take ? req_code : code_q;
    if (take)        epc_d = i_pc;
    else if (we_epc) epc_d = i_data[31:2];
    else             epc_d = epc_q;
  end

  // Clears first, then sets, so a same-cycle set survives W1C.
  always_comb begin
    pend_d = pend_q;
    if (we_cause) pend_d = pend_d & ~i_data[8 +: NPEND];
`ifdef COP0_TIMER_EN
    if (we_compare) pend_d[NUM_IRQ] = 1'b0;
    if (tmr_hit)    pend_d[NUM_IRQ] = 1'b1;
`endif
    pend_d[NUM_IRQ-1:0] = pend_d[NUM_IRQ-1:0] | irq_rise;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      status_q   <= STATUS_RST;
      pend_q     <= '0;
      code_q     <= 5'd0;
      epc_q      <= 30'd0;
      irq_prev_q <= '0;
    end else begin
      status_q   <= status_d;
      pend_q     <= pend_d;
      code_q     <= code_d;
      epc_q      <= epc_d;
      irq_prev_q <= i_irq;
    end
  end

  always_comb begin
    cause_rd             = 32'd0;
    cause_rd[6:2]        = code_q;
    cause_rd[8 +: NPEND] = pend_q;
  end

  always_comb begin
    case (i_addr)
      ADDR_STATUS:  o_data = status_q;
      ADDR_CAUSE:   o_data = cause_rd;
      ADDR_EPC:     o_data = {epc_q, 2'b00};
`ifdef COP0_TIMER_EN
      ADDR_COUNT:   o_data = count_q;
      ADDR_COMPARE: o_data = compare_q;
`endif
      default:      o_data = 32'd0;
    endcase
  end

  assign o_interrupt   = take;
  assign o_instr_addr  = take ? vec_addr : 30'd0;
  assign o_return_addr = epc_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_coproc0_vec.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_coproc0_vec
// Brief    : Directed self-checking bench for pipeline_coproc0_vec (NUM_IRQ=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_coproc0_vec;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_we;
  logic [31:0] i_addr;
  logic [31:0] i_data;
  logic [29:0] i_pc;
  logic        i_overflow;
  logic        i_invalid_instr;
  logic [3:0]  i_irq;
  logic        i_eret;
  logic [31:0] o_data;
  logic [29:0] o_return_addr;
  logic [29:0] o_instr_addr;
  logic        o_interrupt;
  logic        o_busy;

  int n_checks = 0;
  int n_errors = 0;

  pipeline_coproc0_vec #(
    .NUM_IRQ(4), .VECTOR_BASE(30'h002), .VECTOR_STRIDE(30'h004)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_we(i_we), .i_addr(i_addr),
    .i_data(i_data), .i_pc(i_pc), .i_overflow(i_overflow),
    .i_invalid_instr(i_invalid_instr), .i_irq(i_irq), .i_eret(i_eret),
    .o_data(o_data), .o_return_addr(o_return_addr), .o_instr_addr(o_instr_addr),
    .o_interrupt(o_interrupt), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge i_clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cyc();
    i_we = 1'b1; i_addr = a; i_data = d;
    cyc();
    i_we = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    i_addr = a;
    #1;
    check(tag, o_data, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst_n = 1'b0; i_we = 1'b0; i_addr = 32'd0; i_data = 32'd0; i_pc = 30'd0;
    i_overflow = 1'b0; i_invalid_instr = 1'b0; i_irq = 4'd0; i_eret = 1'b0;
    repeat (2) cyc();
    i_rst_n = 1'b1;
    #1;
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_int", {31'd0, o_interrupt}, 32'd0);
    check("rst_vec", {2'd0, o_instr_addr}, 32'd0);
    check("rst_epc", {2'd0, o_return_addr}, 32'd0);
    rd("rst_status", 32'h60, 32'h8000_0003);
    rd("rst_cause", 32'h68, 32'd0);
    rd("rst_epcreg", 32'h70, 32'd0);
    rd("unmapped", 32'h64, 32'd0);

    // Overflow taken from IDLE
    cyc();
    i_pc = 30'h100; i_overflow = 1'b1;
    #1;
    check("ovf_int", {31'd0, o_interrupt}, 32'd1);
    check("ovf_vec", {2'd0, o_instr_addr}, 32'h0000_0002);
    cyc();
    i_overflow = 1'b0; i_invalid_instr = 1'b1;
    #1;
    check("ovf_epc", {2'd0, o_return_addr}, 32'h100);
    check("ovf_busy", {31'd0, o_busy}, 32'd1);
    check("busy_drop_int", {31'd0, o_interrupt}, 32'd0);
    rd("ovf_cause", 32'h68, 32'd0);
    cyc();
    i_invalid_instr = 1'b0; i_eret = 1'b1;
    cyc();
    i_eret = 1'b0;
    #1;
    check("eret_busy", {31'd0, o_busy}, 32'd0);
    check("dropped_int", {31'd0, o_interrupt}, 32'd0);

    // Invalid instruction taken from IDLE
    i_invalid_instr = 1'b1; i_pc = 30'h123;
    #1;
    check("inv_int", {31'd0, o_interrupt}, 32'd1);
    check("inv_vec", {2'd0, o_instr_addr}, 32'h6);
    cyc();
    i_invalid_instr = 1'b0;
    rd("inv_cause", 32'h68, 32'h4);
    rd("inv_epcreg", 32'h70, 32'h48C);
    i_eret = 1'b1;
    cyc();
    i_eret = 1'b0;

    // Two IRQs in the same cycle: irq1 first, then irq2 after eret
    wr(32'h60, 32'h8000_0F00);
    i_irq = 4'b0110;
    #1;
    check("irq_edge_lat", {31'd0, o_interrupt}, 32'd0);
    cyc();
    i_irq = 4'b0000;
    #1;
    check("irq1_int", {31'd0, o_interrupt}, 32'd1);
    check("irq1_vec", {2'd0, o_instr_addr}, 32'h0E);
    cyc();
    rd("irq1_cause", 32'h68, 32'h60C);
    wr(32'h68, 32'h200);
    rd("w1c_cause", 32'h68, 32'h40C);
    i_eret = 1'b1;
    #1;
    check("eret_cyc_int", {31'd0, o_interrupt}, 32'd0);
    cyc();
    i_eret = 1'b0;
    #1;
    check("irq2_int", {31'd0, o_interrupt}, 32'd1);
    check("irq2_vec", {2'd0, o_instr_addr}, 32'h12);
    cyc();
    rd("irq2_cause", 32'h68, 32'h410);
    wr(32'h68, 32'h400);
    i_eret = 1'b1;
    cyc();
    i_eret = 1'b0;
    #1;
    check("irq2_done", {31'd0, o_busy}, 32'd0);

    // IRQ arriving while BUSY waits for eret; set beats same-cycle W1C
    i_irq = 4'b1000;
    cyc();
    i_irq = 4'b0000;
    #1;
    check("irq3_vec", {2'd0, o_instr_addr}, 32'h16);
    cyc();
    wr(32'h68, 32'h800);
    i_irq = 4'b0001;
    cyc();
    #1;
    check("busy_irq0", {31'd0, o_interrupt}, 32'd0);
    i_irq = 4'b0011; i_we = 1'b1; i_addr = 32'h68; i_data = 32'h200;
    cyc();
    i_we = 1'b0;
    rd("set_wins", 32'h68, 32'h314);
    i_eret = 1'b1;
    #1;
    check("busy_eret_int", {31'd0, o_interrupt}, 32'd0);
    cyc();
    i_eret = 1'b0;
    #1;
    check("irq0_int", {31'd0, o_interrupt}, 32'd1);
    check("irq0_vec", {2'd0, o_instr_addr}, 32'h0A);
    cyc();
    wr(32'h68, 32'h300);
    i_eret = 1'b1;
    cyc();
    i_eret = 1'b0; i_irq = 4'b0000;
    #1;
    check("irq0_done", {31'd0, o_busy}, 32'd0);
    check("irq0_none", {31'd0, o_interrupt}, 32'd0);

    // GIE cleared: nothing taken, EPC untouched
    wr(32'h60, 32'h0000_0F03);
    i_pc = 30'h3FF; i_invalid_instr = 1'b1;
    #1;
    check("gie0_int", {31'd0, o_interrupt}, 32'd0);
    cyc();
    i_invalid_instr = 1'b0;
    rd("gie0_epc", 32'h70, 32'h48C);
    check("gie0_busy", {31'd0, o_busy}, 32'd0);

    // EPC software write, then take beats a same-cycle EPC write
    wr(32'h70, 32'h0000_1237);
    rd("epc_wr", 32'h70, 32'h1234);
    check("epc_wr_out", {2'd0, o_return_addr}, 32'h48D);
    wr(32'h60, 32'h8000_0003);
    i_overflow = 1'b1; i_pc = 30'h55;
    i_we = 1'b1; i_addr = 32'h70; i_data = 32'h999C;
    #1;
    check("race_int", {31'd0, o_interrupt}, 32'd1);
    cyc();
    i_overflow = 1'b0; i_we = 1'b0;
    #1;
    check("race_epc", {2'd0, o_return_addr}, 32'h55);
    check("race_busy", {31'd0, o_busy}, 32'd1);

    // Asynchronous reset in the middle of a handler
    #2;
    i_rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, o_busy}, 32'd0);
    check("mid_rst_epc", {2'd0, o_return_addr}, 32'd0);
    rd("mid_rst_status", 32'h60, 32'h8000_0003);
    rd("mid_rst_cause", 32'h68, 32'd0);
    cyc();
    i_rst_n = 1'b1;

`ifdef COP0_TIMER_EN
    wr(32'h88, 32'd10);
    i_we = 1'b1; i_addr = 32'h80; i_data = 32'd0;
    cyc();
    i_addr = 32'h60; i_data = 32'h8000_1000;
    #1;
    check("tmr_m0", {31'd0, o_interrupt}, 32'd0);
    for (int m = 1; m <= 10; m++) begin
      cyc();
      if (m == 1) i_we = 1'b0;
      #1;
      check($sformatf("tmr_m%0d", m), {31'd0, o_interrupt}, (m == 10) ? 32'd1 : 32'd0);
      if (m == 5) rd("tmr_count", 32'h80, 32'd5);
    end
    check("tmr_vec", {2'd0, o_instr_addr}, 32'h1A);
`else
    wr(32'h80, 32'd5);
    rd("no_count", 32'h80, 32'd0);
    wr(32'h88, 32'd7);
    rd("no_compare", 32'h88, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipeline_coproc0_vec.md
Name: pipeline_coproc0_vec

Overview:
Parametrised, vectored successor of the coprocessor-0 exception unit. Handles two synchronous exceptions (overflow, invalid instruction) and NUM_IRQ edge-latched external interrupt lines. Prioritises requests, saves EPC and issues a per-source vector address to the fetch stage. Sits beside the pipeline's execute stage, memory-mapped on the coprocessor bus (i_we/i_addr/i_data/o_data).

Parameters:
NUM_IRQ, 4, external interrupt lines; legal range 1..22.
VECTOR_BASE, 30'h002, word address of vector for code 0.
VECTOR_STRIDE, 30'h004, word distance between consecutive vectors.

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_we  in  1  coprocessor register write strobe
i_addr  in  32  register byte address
i_data  in  32  write data
i_pc  in  30  word PC of faulting/interrupted instruction
i_overflow  in  1  overflow exception (valid this cycle only)
i_invalid_instr  in  1  invalid-instruction exception (valid this cycle only)
i_irq  in  NUM_IRQ  external interrupt lines, rising-edge sensitive
i_eret  in  1  return-from-exception strobe
o_data  out  32  register read data (combinational on i_addr)
o_return_addr  out  30  current EPC
o_instr_addr  out  30  vector address, meaningful when o_interrupt=1, else 0
o_interrupt  out  1  exception taken this cycle (combinational, flush strobe)
o_busy  out  1  handler in progress

Behaviour:
- Reset: status=32'h80000003, cause=0, epc=0, irq edge history=0, state IDLE. Outputs: o_busy=0, o_interrupt=0, o_instr_addr=0, o_return_addr=0.
- Register map: 0x60 status (RW); 0x68 cause; 0x70 epc (RW, stored as i_data[31:2], read as {epc,2'b00}); other addresses read 0.
- Status: bit31 GIE, bit0 overflow mask, bit1 invalid mask, bits[8+k] mask for irq k. Unused bits write/read as written.
- Cause: bits[8+k] irq pending, write-1-to-clear. Bits[6:2] code of last taken exception, read-only. Other bits read 0.
- Pending set on registered rising edge of i_irq[k] (prev=0, now=1). Same-cycle set and W1C on one bit: set wins.
- Codes: overflow=0, invalid=1, irq k=2+k. Priority: lowest code wins.
- take = GIE & state==IDLE & any(masked request). On take: o_interrupt=1 same cycle; o_instr_addr=VECTOR_BASE+code*VECTOR_STRIDE (30-bit, wraps); next edge epc<=i_pc, cause[6:2]<=code, state->BUSY.
- Pending bit is not cleared by take; the handler clears it via W1C.
- FSM: IDLE -take-> BUSY; BUSY -i_eret-> IDLE. i_eret in IDLE is a no-op. Requests arriving in BUSY: irq stays pending, taken after eret; synchronous exceptions in BUSY are dropped.
- Same-cycle take and software epc write: take wins.
- o_busy = (state==BUSY). Reset mid-handler returns to IDLE with all registers at reset values.

Optional Feature:
Macro COP0_TIMER_EN. When defined:
- Adds count (0x80, RW) and compare (0x88, RW) registers, both reset 0.
- count increments every cycle and wraps 32'hFFFFFFFF->0. A software write loads count instead of incrementing.
- When the incremented count equals compare, pending bit [8+NUM_IRQ] is set. A write to compare clears it; it is also W1C via cause.
- Timer mask is status[8+NUM_IRQ]; timer code is 2+NUM_IRQ, with lowest priority.
When not defined: 0x80/0x88 read 0, writes are ignored, and no timer bit exists.

Test Plan:
- Reset, then read 0x60 -> 32'h80000003; 0x68 and 0x70 -> 0; o_busy=0.
- i_overflow=1 with i_pc=30'h100 -> o_interrupt=1, o_instr_addr=30'h002 same cycle. Next cycle: o_return_addr=30'h100, cause[6:2]=0, o_busy=1. Then i_eret -> o_busy=0.
- Write status=32'h80000F00, pulse i_irq[2] and i_irq[1] in the same cycle -> irq1 taken first with vector 30'h002+3*4=30'h00E. Write 0x68=32'h200 then eret -> irq2 taken next cycle, vector 30'h012.
- While BUSY, i_irq[0] rises with mask set -> no o_interrupt. After i_eret -> taken in the cycle following eret.
- GIE=0 (status=32'h00000F03), i_invalid_instr=1 -> o_interrupt=0, epc unchanged.
- COP0_TIMER_EN, NUM_IRQ=4: write compare=10, count=0, status bit12=1 -> o_interrupt exactly 10 cycles after the count write, vector 30'h002+6*4=30'h01A.
